// File: rtl/radix_4_div_pkg.sv
// Shared radix-4 divider definitions: one-hot quotient digit
// bit positions and the on-the-fly conversion FSM states.
package radix_4_div_pkg;

    localparam int QUOT_ONEHOT_WIDTH = 5;

    localparam int QUOT_NEG_2 = 0;
    localparam int QUOT_NEG_1 = 1;
    localparam int QUOT_ZERO  = 2;
    localparam int QUOT_POS_1 = 3;
    localparam int QUOT_POS_2 = 4;

    typedef enum logic [1:0] {
        OTFC_IDLE = 2'd0,
        OTFC_ITER = 2'd1,
        OTFC_CORR = 2'd2,
        OTFC_DONE = 2'd3
    } otfc_state_t;

endpackage

// File: rtl/radix_4_otfc_v1_if.sv
// Handshake bundle between the divider loop (master) and the
// on-the-fly converter (slave).
interface radix_4_otfc_v1_if #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = $clog2(WIDTH / 2 + 1)
);
    import radix_4_div_pkg::*;

    logic                         flush_i;
    logic                         start_valid_i;
    logic                         start_ready_o;
    logic [ITER_W-1:0]            iter_num_i;
    logic                         digit_valid_i;
    logic                         digit_ready_o;
    logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i;
    logic                         rem_valid_i;
    logic                         rem_neg_i;
    logic                         quot_valid_o;
    logic                         quot_ready_i;
    logic [WIDTH-1:0]             quot_o;
    logic                         digit_err_o;

    modport master (
        output flush_i, start_valid_i, iter_num_i,
        output digit_valid_i, quot_digit_i,
        output rem_valid_i, rem_neg_i, quot_ready_i,
        input  start_ready_o, digit_ready_o,
        input  quot_valid_o, quot_o, digit_err_o
    );

    modport slave (
        input  flush_i, start_valid_i, iter_num_i,
        input  digit_valid_i, quot_digit_i,
        input  rem_valid_i, rem_neg_i, quot_ready_i,
        output start_ready_o, digit_ready_o,
        output quot_valid_o, quot_o, digit_err_o
    );

endinterface

// File: rtl/radix_4_otfc_step.sv
// One on-the-fly conversion step: appends a radix-4 digit to the
// Q / QM pair. Non-one-hot digits are flagged and act as zero.
module radix_4_otfc_step
    import radix_4_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]             i_q,
    input  logic [WIDTH-1:0]             i_qm,
    input  logic [QUOT_ONEHOT_WIDTH-1:0] i_digit,
    output logic [WIDTH-1:0]             o_q,
    output logic [WIDTH-1:0]             o_qm,
    output logic                         o_illegal
);

    logic [WIDTH-3:0] w_q_sh;
    logic [WIDTH-3:0] w_qm_sh;

    assign w_q_sh  = i_q[WIDTH-3:0];
    assign w_qm_sh = i_qm[WIDTH-3:0];

    // select source register and appended 2-bit pattern per digit
    always_comb begin
        o_illegal = ($countones(i_digit) != 1);
        o_q       = {w_q_sh, 2'd0};
        o_qm      = {w_qm_sh, 2'd3};
        if (!o_illegal) begin
            unique case (1'b1)
                i_digit[QUOT_NEG_2]: begin
                    o_q  = {w_qm_sh, 2'd2};
                    o_qm = {w_qm_sh, 2'd1};
                end
                i_digit[QUOT_NEG_1]: begin
                    o_q  = {w_qm_sh, 2'd3};
                    o_qm = {w_qm_sh, 2'd2};
                end
                i_digit[QUOT_ZERO]: begin
                    o_q  = {w_q_sh, 2'd0};
                    o_qm = {w_qm_sh, 2'd3};
                end
                i_digit[QUOT_POS_1]: begin
                    o_q  = {w_q_sh, 2'd1};
                    o_qm = {w_q_sh, 2'd0};
                end
                i_digit[QUOT_POS_2]: begin
                    o_q  = {w_q_sh, 2'd2};
                    o_qm = {w_q_sh, 2'd1};
                end
                default: begin
                    o_q  = {w_q_sh, 2'd0};
                    o_qm = {w_qm_sh, 2'd3};
                end
            endcase
        end
    end

endmodule

// File: rtl/radix_4_otfc_v1.sv
// Radix-4 on-the-fly quotient converter with final remainder-sign
// correction and valid/ready result output.
module radix_4_otfc_v1
    import radix_4_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    radix_4_otfc_v1_if.slave  bus
);

    localparam int ITER_W = $clog2(WIDTH / 2 + 1);

    otfc_state_t       r_state;
    otfc_state_t       w_next;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_qm;
    logic [WIDTH-1:0]  r_quot;
    logic [ITER_W-1:0] r_cnt;
    logic              r_err;

    logic [WIDTH-1:0]  w_q_nxt;
    logic [WIDTH-1:0]  w_qm_nxt;
    logic              w_illegal;
    logic [ITER_W-1:0] w_iter_init;
    logic              w_start_hs;
    logic              w_digit_hs;
    logic              w_rem_hs;
    logic              w_quot_hs;
    logic              w_last;

    radix_4_otfc_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q       (r_q),
        .i_qm      (r_qm),
        .i_digit   (bus.quot_digit_i),
        .o_q       (w_q_nxt),
        .o_qm      (w_qm_nxt),
        .o_illegal (w_illegal)
    );

    assign w_start_hs = bus.start_valid_i & ~bus.flush_i
                      & (r_state == OTFC_IDLE);
    assign w_digit_hs = bus.digit_valid_i & ~bus.flush_i
                      & (r_state == OTFC_ITER);
    assign w_rem_hs   = bus.rem_valid_i & ~bus.flush_i
                      & (r_state == OTFC_CORR);
    assign w_quot_hs  = bus.quot_ready_i & ~bus.flush_i
                      & (r_state == OTFC_DONE);
    assign w_last     = w_digit_hs & (r_cnt == ITER_W'(1));

    // a zero digit count still runs one iteration
    assign w_iter_init = (bus.iter_num_i == '0) ? ITER_W'(1)
                                                : bus.iter_num_i;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= OTFC_IDLE;
        else     r_state <= w_next;
    end

    // next-state logic; flush overrides every handshake
    always_comb begin
        w_next = r_state;
        if (bus.flush_i) begin
            w_next = OTFC_IDLE;
        end else begin
            unique case (r_state)
                OTFC_IDLE: if (w_start_hs) w_next = OTFC_ITER;
                OTFC_ITER: if (w_last)     w_next = OTFC_CORR;
                OTFC_CORR: if (w_rem_hs)   w_next = OTFC_DONE;
                OTFC_DONE: if (w_quot_hs)  w_next = OTFC_IDLE;
                default:                   w_next = OTFC_IDLE;
            endcase
        end
    end

    // handshake outputs decoded from the current state
    always_comb begin
        bus.start_ready_o = (r_state == OTFC_IDLE);
        bus.digit_ready_o = (r_state == OTFC_ITER);
        bus.quot_valid_o  = (r_state == OTFC_DONE);
        bus.quot_o        = r_quot;
        bus.digit_err_o   = r_err;
    end

    // Q/QM conversion registers, digit counter, result and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_qm   <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_start_hs) begin
                r_q   <= '0;
                r_qm  <= '1;
                r_cnt <= w_iter_init;
                r_err <= 1'b0;
            end
            if (w_digit_hs) begin
                r_q   <= w_q_nxt;
                r_qm  <= w_qm_nxt;
                r_cnt <= r_cnt - ITER_W'(1);
                if (w_illegal) r_err <= 1'b1;
            end
            if (w_rem_hs) begin
                r_quot <= bus.rem_neg_i ? r_qm : r_q;
            end
        end
    end

endmodule

// File: tb/tb_radix_4_otfc_v1.sv
// Randomized + directed bench for radix_4_otfc_v1 at WIDTH 8 and 32,
// checked against an arithmetic model of the quotient value.
module tb_radix_4_otfc_v1;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       start_valid;
    logic       en8;
    logic [4:0] iter;
    logic       digit_valid;
    logic [4:0] digit;
    logic       rem_valid;
    logic       rem_neg;
    logic       quot_ready;

    int total = 0;
    int bad   = 0;

    logic [4:0] code [16];

    always #5 clk = ~clk;

    radix_4_otfc_v1_if #(.WIDTH(8))  b8 ();
    radix_4_otfc_v1_if #(.WIDTH(32)) b32 ();

    assign b8.flush_i        = flush;
    assign b8.start_valid_i  = start_valid & en8;
    assign b8.iter_num_i     = iter[2:0];
    assign b8.digit_valid_i  = digit_valid;
    assign b8.quot_digit_i   = digit;
    assign b8.rem_valid_i    = rem_valid;
    assign b8.rem_neg_i      = rem_neg;
    assign b8.quot_ready_i   = quot_ready;

    assign b32.flush_i       = flush;
    assign b32.start_valid_i = start_valid;
    assign b32.iter_num_i    = iter;
    assign b32.digit_valid_i = digit_valid;
    assign b32.quot_digit_i  = digit;
    assign b32.rem_valid_i   = rem_valid;
    assign b32.rem_neg_i     = rem_neg;
    assign b32.quot_ready_i  = quot_ready;

    radix_4_otfc_v1 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    radix_4_otfc_v1 #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    // value of a one-hot digit; anything else counts as 0
    function automatic int dval(input logic [4:0] c);
        if ($countones(c) != 1) return 0;
        for (int b = 0; b < 5; b++) if (c[b]) return b - 2;
        return 0;
    endfunction

    function automatic logic [4:0] oh(input int d);
        return 5'd1 << (d + 2);
    endfunction

    // stall: 0 none, 1 every digit (alternate cycles), 2 random
    task automatic run(input int n, input bit rn, input int stall,
                       input int hold);
        int     nn;
        longint val;
        bit     err;
        int     w;
        nn  = (n == 0) ? 1 : n;
        en8 = (nn <= 4);
        val = 0;
        err = 0;
        @(negedge clk);
        start_valid = 1'b1;
        iter        = 5'(n);
        chk("start_rdy", 64'(b32.start_ready_o), 64'd1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("err_clr", 64'(b32.digit_err_o), 64'd0);
        chk("cnt_init", 64'(dut32.r_cnt), 64'(nn));
        chk("dig_rdy", 64'(b32.digit_ready_o), 64'd1);
        for (int i = 0; i < nn; i++) begin
            if (stall == 1 || (stall == 2 && $urandom_range(0, 2) == 0))
            begin
                digit_valid = 1'b0;
                digit       = oh(2);
                @(negedge clk);
                chk("stall_cnt", 64'(dut32.r_cnt), 64'(nn - i));
                chk("stall_q", 64'(dut32.r_q), m(val, 32));
            end
            digit_valid = 1'b1;
            digit       = code[i];
            @(negedge clk);
            digit_valid = 1'b0;
            val = val * 4 + dval(code[i]);
            if ($countones(code[i]) != 1) err = 1;
            chk("q32", 64'(dut32.r_q), m(val, 32));
            chk("qm32", 64'(dut32.r_qm), m(val - 1, 32));
            if (en8) begin
                chk("q8", 64'(dut8.r_q), m(val, 8));
                chk("qm8", 64'(dut8.r_qm), m(val - 1, 8));
            end
        end
        chk("corr_drdy", 64'(b32.digit_ready_o), 64'd0);
        chk("corr_qv", 64'(b32.quot_valid_o), 64'd0);
        w = $urandom_range(0, 2);
        for (int k = 0; k < w; k++) begin
            digit_valid = 1'b1;
            digit       = oh(2);
            rem_neg     = ~rn;
            @(negedge clk);
            digit_valid = 1'b0;
        end
        chk("corr_q", 64'(dut32.r_q), m(val, 32));
        rem_valid = 1'b1;
        rem_neg   = rn;
        @(negedge clk);
        rem_valid = 1'b0;
        rem_neg   = ~rn;
        if (rn) val = val - 1;
        chk("qvalid", 64'(b32.quot_valid_o), 64'd1);
        chk("quot32", 64'(b32.quot_o), m(val, 32));
        chk("err32", 64'(b32.digit_err_o), 64'(err));
        if (en8) begin
            chk("quot8", 64'(b8.quot_o), m(val, 8));
            chk("err8", 64'(b8.digit_err_o), 64'(err));
        end
        for (int k = 0; k < hold; k++) begin
            quot_ready = 1'b0;
            @(negedge clk);
            chk("hold_q", 64'(b32.quot_o), m(val, 32));
            chk("hold_srdy", 64'(b32.start_ready_o), 64'd0);
            chk("hold_qv", 64'(b32.quot_valid_o), 64'd1);
        end
        quot_ready = 1'b1;
        @(negedge clk);
        quot_ready = 1'b0;
        chk("idle_srdy", 64'(b32.start_ready_o), 64'd1);
        chk("idle_qv", 64'(b32.quot_valid_o), 64'd0);
    endtask

    initial begin
        longint v;
        rst         = 1'b1;
        flush       = 1'b0;
        start_valid = 1'b0;
        en8         = 1'b1;
        iter        = '0;
        digit_valid = 1'b0;
        digit       = '0;
        rem_valid   = 1'b0;
        rem_neg     = 1'b0;
        quot_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_quot", 64'(b32.quot_o), 64'd0);
        chk("rst_err", 64'(b32.digit_err_o), 64'd0);
        chk("rst_srdy", 64'(b32.start_ready_o), 64'd1);
        chk("rst_qv", 64'(b32.quot_valid_o), 64'd0);
        chk("rst_q", 64'(dut32.r_q), 64'd0);
        chk("rst_qm", 64'(dut32.r_qm), 64'd0);

        code[0] = oh(1);
        code[1] = oh(-1);
        run(2, 1'b0, 0, 0);
        chk("dir_03", 64'(b8.quot_o), 64'h03);
        run(2, 1'b1, 0, 1);
        chk("dir_02", 64'(b8.quot_o), 64'h02);

        code[0] = oh(-2);
        code[1] = oh(2);
        run(2, 1'b0, 0, 0);
        chk("dir_fa", 64'(b8.quot_o), 64'hFA);

        for (int i = 0; i < 16; i++) code[i] = oh(2);
        run(16, 1'b0, 0, 0);
        chk("dir_aa", 64'(b32.quot_o), 64'hAAAAAAAA);
        run(16, 1'b0, 1, 0);
        chk("dir_aa_st", 64'(b32.quot_o), 64'hAAAAAAAA);

        code[0] = 5'b00110;
        code[1] = oh(1);
        run(2, 1'b0, 0, 5);
        chk("dir_ill", 64'(b8.quot_o), 64'h01);

        code[0] = oh(-1);
        run(0, 1'b1, 0, 0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 9) == 0)
                    code[i] = ($urandom_range(0, 1) == 1) ? 5'b11111
                                                          : 5'b01010;
                else
                    code[i] = oh($urandom_range(0, 4) - 2);
            end
            run($urandom_range(0, 16), 1'($urandom_range(0, 1)), 2,
                $urandom_range(0, 3));
        end

        en8 = 1'b1;
        @(negedge clk);
        start_valid = 1'b1;
        iter        = 5'd4;
        @(negedge clk);
        start_valid = 1'b0;
        v = 0;
        for (int i = 0; i < 3; i++) begin
            digit_valid = 1'b1;
            digit       = oh(1);
            v = v * 4 + 1;
            @(negedge clk);
        end
        flush = 1'b1;
        digit = oh(2);
        @(negedge clk);
        flush       = 1'b0;
        digit_valid = 1'b0;
        chk("fl_srdy", 64'(b32.start_ready_o), 64'd1);
        chk("fl_drdy", 64'(b32.digit_ready_o), 64'd0);
        chk("fl_qv", 64'(b32.quot_valid_o), 64'd0);
        chk("fl_cnt", 64'(dut32.r_cnt), 64'd1);
        chk("fl_q", 64'(dut32.r_q), m(v, 32));
        repeat (2) @(negedge clk);
        chk("fl_qv2", 64'(b32.quot_valid_o), 64'd0);

        @(negedge clk);
        start_valid = 1'b1;
        iter        = 5'd2;
        @(negedge clk);
        start_valid = 1'b0;
        digit_valid = 1'b1;
        digit       = 5'b00000;
        @(negedge clk);
        digit = oh(1);
        @(negedge clk);
        digit_valid = 1'b0;
        chk("pre_err", 64'(b32.digit_err_o), 64'd1);
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        chk("mr_quot", 64'(b32.quot_o), 64'd0);
        chk("mr_err", 64'(b32.digit_err_o), 64'd0);
        chk("mr_srdy", 64'(b32.start_ready_o), 64'd1);
        chk("mr_drdy", 64'(b32.digit_ready_o), 64'd0);
        chk("mr_qv", 64'(b32.quot_valid_o), 64'd0);
        chk("mr_q", 64'(dut32.r_q), 64'd0);
        chk("mr_qm", 64'(dut32.r_qm), 64'd0);
        chk("mr_cnt", 64'(dut32.r_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
